// File: rtl/unwrap_mc.sv
// unwrap_mc: multi-channel, time-interleaved phase unwrapper.
//
// Each input sample is a signed WIN-bit wrapped phase (one turn = 2^WIN
// counts). Per channel the block keeps the previous sample and a signed
// WW-bit turn counter. The output is the unwrapped phase
// (turns << WIN) + sample, WOUT = WW + WIN bits wide.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   sync_in, ch_in, d_in input sample strobe, channel, wrapped phase
//   wrap_ld, wrap_ld_ch,
//   wrap_ld_val          turn-counter preload strobe / channel / value
//   clr_sat              clear all sticky saturation flags
//   sync_out, ch_out,
//   d_out, wrap_out      output strobe, channel, unwrapped phase, turn count
//   sat_out              current output sample hit the counter limit
//   sat_flags            sticky per-channel saturation flags
//
// Pipeline: stage A computes the turn delta from old[ch]; stage B adds it
// to wrap[ch] (or to a coincident preload) and forms the output. Latency
// is 2 clk, one sample per clk.
module unwrap_mc #(
    parameter int NCH  = 4,
    parameter int WIN  = 17,
    parameter int WOUT = 25,
    parameter int SAT  = 1,
    parameter int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sync_in,
    input  logic [CW-1:0]          ch_in,
    input  logic signed [WIN-1:0]  d_in,
    input  logic                   wrap_ld,
    input  logic [CW-1:0]          wrap_ld_ch,
    input  logic signed [WOUT-WIN-1:0] wrap_ld_val,
    input  logic                   clr_sat,
    output logic                   sync_out,
    output logic [CW-1:0]          ch_out,
    output logic signed [WOUT-1:0] d_out,
    output logic signed [WOUT-WIN-1:0] wrap_out,
    output logic                   sat_out,
    output logic [NCH-1:0]         sat_flags
);

    localparam int WW = WOUT - WIN;

    localparam logic signed [WIN:0] HALF  = (WIN+1)'(64'd1 << (WIN - 1));
    localparam logic signed [WIN:0] NHALF = -HALF;
    localparam logic signed [WW-1:0] WMAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] WMIN = {1'b1, {(WW-1){1'b0}}};

    // Per-channel state
    logic signed [WIN-1:0] old_q    [NCH];
    logic signed [WW-1:0]  wrap_q   [NCH];
    logic [NCH-1:0]        primed_q;

    // Stage A registers
    logic                  a_vld;
    logic [CW-1:0]         a_ch;
    logic signed [WIN-1:0] a_d;
    logic signed [1:0]     a_delta;

    // ------------------------------------------------------------------
    // Stage A: turn delta from the previous sample of the same channel
    // ------------------------------------------------------------------
    logic                  in_ok;
    logic signed [WIN-1:0] old_sel;
    logic                  primed_sel;
    logic signed [WIN:0]   diff;
    logic signed [1:0]     delta;

    assign in_ok = sync_in && (int'(ch_in) < NCH);

    always_comb begin
        old_sel    = '0;
        primed_sel = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_in == CW'(i)) begin
                old_sel    = old_q[i];
                primed_sel = primed_q[i];
            end
        end
    end

    always_comb begin
        diff  = {d_in[WIN-1], d_in} - {old_sel[WIN-1], old_sel};
        delta = 2'sd0;
        if (diff >= HALF)
            delta = -2'sd1;
        else if (diff < NHALF)
            delta = 2'sd1;
        // First sample of a channel only establishes the reference.
        if (!primed_sel)
            delta = 2'sd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld    <= 1'b0;
            a_ch     <= '0;
            a_d      <= '0;
            a_delta  <= '0;
            primed_q <= '0;
            for (int unsigned i = 0; i < NCH; i++)
                old_q[i] <= '0;
        end else begin
            a_vld <= in_ok;
            if (in_ok) begin
                a_ch    <= ch_in;
                a_d     <= d_in;
                a_delta <= delta;
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                if (in_ok && ch_in == CW'(i)) begin
                    old_q[i]    <= d_in;
                    primed_q[i] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage B: accumulate turns, saturate or wrap, build output
    // ------------------------------------------------------------------
    logic signed [WW-1:0]   wrap_sel;
    logic signed [WW-1:0]   base;
    logic signed [WW:0]     sum_x;
    logic signed [WW-1:0]   sum;
    logic                   sat_now;
    logic signed [WOUT-1:0] dout_nx;
    logic                   ld_ok;

    assign ld_ok = wrap_ld && (int'(wrap_ld_ch) < NCH);

    always_comb begin
        wrap_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (a_ch == CW'(i))
                wrap_sel = wrap_q[i];
        end
    end

    always_comb begin
        // A preload landing on the channel being accumulated replaces the
        // stored count as the base, so the sample's delta is not lost.
        base    = (wrap_ld && wrap_ld_ch == a_ch) ? wrap_ld_val : wrap_sel;
        sum_x   = {base[WW-1], base} + {{(WW-1){a_delta[1]}}, a_delta};
        sum     = sum_x[WW-1:0];
        sat_now = 1'b0;
        if (SAT != 0 && (sum_x[WW] != sum_x[WW-1])) begin
            sum     = sum_x[WW] ? WMIN : WMAX;
            sat_now = 1'b1;
        end
        dout_nx = {sum, {WIN{1'b0}}} + {{WW{a_d[WIN-1]}}, a_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_out  <= 1'b0;
            ch_out    <= '0;
            d_out     <= '0;
            wrap_out  <= '0;
            sat_out   <= 1'b0;
            sat_flags <= '0;
            for (int unsigned i = 0; i < NCH; i++)
                wrap_q[i] <= '0;
        end else begin
            sync_out <= a_vld;
            if (a_vld) begin
                ch_out   <= a_ch;
                d_out    <= dout_nx;
                wrap_out <= sum;
                sat_out  <= sat_now;
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                if (a_vld && a_ch == CW'(i))
                    wrap_q[i] <= sum;
                else if (ld_ok && wrap_ld_ch == CW'(i))
                    wrap_q[i] <= wrap_ld_val;

                // New saturation takes priority over a coincident clear.
                if (a_vld && sat_now && a_ch == CW'(i))
                    sat_flags[i] <= 1'b1;
                else if (clr_sat)
                    sat_flags[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_unwrap_mc.sv
// Directed bench for unwrap_mc (WIN=8, WOUT=12, so WW=4). Three instances
// share one stimulus: NCH=4/SAT=1, NCH=4/SAT=0 and NCH=3/SAT=1 (the last
// one treats channel 3 as invalid). Inputs are driven on the falling edge;
// outputs are checked on the falling edge two cycles after their sample.
module tb_unwrap_mc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              sync_in;
    logic [1:0]        ch_in;
    logic signed [7:0] d_in;
    logic              wrap_ld;
    logic [1:0]        wrap_ld_ch;
    logic signed [3:0] wrap_ld_val;
    logic              clr_sat;

    logic a_sync, b_sync, c_sync;
    logic [1:0] a_ch, b_ch, c_ch;
    logic signed [11:0] a_d, b_d, c_d;
    logic signed [3:0] a_w, b_w, c_w;
    logic a_sat, b_sat, c_sat;
    logic [3:0] a_flags, b_flags;
    logic [2:0] c_flags;

    unwrap_mc #(.NCH(4), .WIN(8), .WOUT(12), .SAT(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .ch_in(ch_in), .d_in(d_in),
        .wrap_ld(wrap_ld), .wrap_ld_ch(wrap_ld_ch), .wrap_ld_val(wrap_ld_val),
        .clr_sat(clr_sat), .sync_out(a_sync), .ch_out(a_ch), .d_out(a_d),
        .wrap_out(a_w), .sat_out(a_sat), .sat_flags(a_flags));

    unwrap_mc #(.NCH(4), .WIN(8), .WOUT(12), .SAT(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .ch_in(ch_in), .d_in(d_in),
        .wrap_ld(wrap_ld), .wrap_ld_ch(wrap_ld_ch), .wrap_ld_val(wrap_ld_val),
        .clr_sat(clr_sat), .sync_out(b_sync), .ch_out(b_ch), .d_out(b_d),
        .wrap_out(b_w), .sat_out(b_sat), .sat_flags(b_flags));

    unwrap_mc #(.NCH(3), .WIN(8), .WOUT(12), .SAT(1)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .ch_in(ch_in), .d_in(d_in),
        .wrap_ld(wrap_ld), .wrap_ld_ch(wrap_ld_ch), .wrap_ld_val(wrap_ld_val),
        .clr_sat(clr_sat), .sync_out(c_sync), .ch_out(c_ch), .d_out(c_d),
        .wrap_out(c_w), .sat_out(c_sat), .sat_flags(c_flags));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected output of one sample: v=0 means no sync_out expected.
    // d/w/s apply to SAT=1 instances, d0/w0/s0 to the SAT=0 instance.
    typedef struct {
        bit v; int ch; int d; int w; bit s; int d0; int w0; bit s0;
    } exp_t;

    function automatic exp_t NONE();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    function automatic exp_t E(input int ch, input int d, input int w);
        exp_t e;
        e = '{1'b1, ch, d, w, 1'b0, d, w, 1'b0};
        return e;
    endfunction

    function automatic exp_t ES(input int ch, input int d, input int w, input bit s,
                                input int d0, input int w0, input bit s0);
        exp_t e;
        e = '{1'b1, ch, d, w, s, d0, w0, s0};
        return e;
    endfunction

    exp_t p0, p1;

    task automatic check_out(input exp_t p);
        chk("sync_s1", int'(a_sync), int'(p.v));
        chk("sync_s0", int'(b_sync), int'(p.v));
        chk("sync_n3", int'(c_sync), int'(p.v && p.ch < 3));
        if (p.v) begin
            chk("ch_s1",   int'(a_ch), p.ch);
            chk("d_s1",    int'(a_d), p.d);
            chk("wrap_s1", int'(a_w), p.w);
            chk("sat_s1",  int'(a_sat), int'(p.s));
            chk("d_s0",    int'(b_d), p.d0);
            chk("wrap_s0", int'(b_w), p.w0);
            chk("sat_s0",  int'(b_sat), int'(p.s0));
            if (p.ch < 3) begin
                chk("d_n3",    int'(c_d), p.d);
                chk("wrap_n3", int'(c_w), p.w);
            end
        end
    endtask

    // One cycle: check the output of the sample driven two cycles ago,
    // then drive this cycle's inputs.
    task automatic cyc(input bit s, input int ch, input int d, input exp_t e,
                       input bit ld, input int ldch, input int ldval, input bit clr);
        @(negedge clk);
        check_out(p1);
        p1 = p0;
        p0 = e;
        sync_in     = s;
        ch_in       = 2'(ch);
        d_in        = 8'(d);
        wrap_ld     = ld;
        wrap_ld_ch  = 2'(ldch);
        wrap_ld_val = 4'(ldval);
        clr_sat     = clr;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, NONE(), 1'b0, 0, 0, 1'b0);
    endtask

    task automatic smp(input int ch, input int d, input exp_t e);
        cyc(1'b1, ch, d, e, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        sync_in = 0; ch_in = '0; d_in = '0;
        wrap_ld = 0; wrap_ld_ch = '0; wrap_ld_val = '0; clr_sat = 0;
        p0 = NONE();
        p1 = NONE();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sync",  int'(a_sync), 0);
        chk("rst_ch",    int'(a_ch), 0);
        chk("rst_d",     int'(a_d), 0);
        chk("rst_wrap",  int'(a_w), 0);
        chk("rst_sat",   int'(a_sat), 0);
        chk("rst_flags", int'(a_flags), 0);
        rst_n = 1'b1;

        // Priming and positive wrap on ch0
        smp(0, 100,  E(0, 100, 0));
        smp(0, 120,  E(0, 120, 0));
        smp(0, 126,  E(0, 126, 0));
        smp(0, -126, E(0, 130, 1));
        smp(0, -100, E(0, 156, 1));

        // Interleave with negative wrap on ch1
        smp(1, -120, E(1, -120, 0));
        smp(2, 5,    E(2, 5, 0));
        smp(1, 120,  E(1, -136, -1));

        // Preload colliding with a stage-B sample on ch3 (invalid for NCH=3)
        smp(3, 120,  E(3, 120, 0));
        smp(3, -126, E(3, 1410, 6));
        cyc(1'b0, 0, 0, NONE(), 1'b1, 3, 5, 1'b0);
        smp(3, -126, E(3, 1410, 6));

        // Move ch0 reference to 120 without a turn, then preload to 7
        smp(0, 0,   E(0, 256, 1));
        smp(0, 120, E(0, 376, 1));
        idle();
        cyc(1'b0, 0, 0, NONE(), 1'b1, 0, 7, 1'b0);

        // +1 turn at count 7: clamps with SAT=1, wraps to -8 with SAT=0
        smp(0, -120, ES(0, 1672, 7, 1'b1, 1928, -8, 1'b0));
        idle();
        idle();
        chk("flags_s1_set", int'(a_flags), 1);
        chk("flags_s0",     int'(b_flags), 0);
        chk("flags_n3_set", int'(c_flags), 1);
        idle();
        chk("flags_s1_hold", int'(a_flags), 1);

        cyc(1'b0, 0, 0, NONE(), 1'b0, 0, 0, 1'b1);
        idle();
        chk("flags_s1_clr", int'(a_flags), 0);

        // -1 turn onto a -8 preload together with clr_sat: saturation wins
        smp(0, 120, ES(0, -1928, -8, 1'b1, 1912, 7, 1'b0));
        cyc(1'b0, 0, 0, NONE(), 1'b1, 0, -8, 1'b1);
        idle();
        chk("flags_s1_clr_vs_sat", int'(a_flags), 1);
        chk("flags_s0_clr_vs_sat", int'(b_flags), 0);

        // Reset with samples in flight: none may emerge
        smp(1, 50, NONE());
        smp(2, 60, NONE());
        #1;
        rst_n   = 1'b0;
        sync_in = 1'b0;
        idle();
        idle();
        chk("midrst_flags", int'(a_flags), 0);
        chk("midrst_d",     int'(a_d), 0);
        rst_n = 1'b1;
        idle();

        // Channels re-prime after reset
        smp(0, -100, E(0, -100, 0));
        smp(3, 100,  E(3, 100, 0));
        idle();
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/unwrap_mc.md
Name: unwrap_mc

Overview:
- Multi-channel, time-interleaved phase unwrapper. Successor to the single-channel unwrap.
- Each input sample is a signed WIN-bit phase word; one full turn equals 2^WIN counts.
- Keeps a per-channel last-sample and turn counter, and emits a WOUT-bit unwrapped phase.
- Sits after CORDIC/phase-detect stages, ahead of frequency/phase-tracking loops.
- Adds per-channel turn preload, first-sample priming and optional counter saturation with sticky flags.

Parameters:
- NCH, 4, number of interleaved channels (1..64).
- WIN, 17, input phase width; 2^WIN counts per turn.
- WOUT, 25, output width; WW = WOUT-WIN turn-counter bits (WW >= 2).
- SAT, 1, 1 = saturate the turn counter at its signed limits; 0 = modulo wrap.
- CW, max(1,clog2(NCH)), channel index width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sync_in  in  1  sample strobe; any duty cycle, back-to-back allowed.
- ch_in  in  CW  channel of the current sample; values >= NCH are ignored (no state update, no sync_out).
- d_in  in  WIN  signed wrapped phase.
- wrap_ld  in  1  turn-counter preload strobe.
- wrap_ld_ch  in  CW  preload target channel.
- wrap_ld_val  in  WW  signed preload value.
- clr_sat  in  1  clears all sticky saturation flags.
- sync_out  out  1  output strobe.
- ch_out  out  CW  channel of the output sample.
- d_out  out  WOUT  signed unwrapped phase.
- wrap_out  out  WW  turn count used for d_out.
- sat_out  out  1  this output sample was saturated.
- sat_flags  out  NCH  sticky per-channel saturation flags.

Behaviour:
- Reset: asynchronous on rst_n low. Every output, old[], wrap[], primed[], sat_flags and pipeline registers go to 0.
- Stage A (edge after sync_in with a valid ch_in):
  - diff = sext(d_in) - sext(old[ch]), computed at WIN+1 bits.
  - delta = -1 if diff >= 2^(WIN-1); +1 if diff < -2^(WIN-1); else 0.
  - If primed[ch] = 0, delta = 0, and primed[ch] is set.
  - old[ch] <= d_in. The stage-A registers capture ch, d_in, delta.
- Stage B (edge after stage A valid):
  - base = wrap_ld_val if wrap_ld and wrap_ld_ch == ch; else wrap[ch].
  - sum = base + delta.
  - Overflow with SAT=1: clamp to +2^(WW-1)-1 or -2^(WW-1), and set sat_out and sat_flags[ch].
  - Overflow with SAT=0: two's-complement wrap; sat_out stays 0.
  - wrap[ch] <= sum.
  - d_out <= (sum << WIN) + sext(d_in), wrapping modulo 2^WOUT.
  - wrap_out <= sum; ch_out <= ch; sync_out <= 1 for one cycle per sample.
- Latency: exactly 2 clk from sync_in to sync_out. Throughput: one sample per clk.
- Same channel on consecutive cycles needs no stall:
  - old[] is written in stage A and read by the next stage A.
  - wrap[] is written in stage B and read by the next stage B.
- wrap_ld with no coincident stage-B sample on that channel: wrap[wrap_ld_ch] <= wrap_ld_val immediately; primed is unaffected.
- wrap_ld with an invalid channel index: ignored.
- clr_sat together with a new saturation on the same cycle: the new saturation wins, so the flag stays set.
- Stage registers hold their values when sync_in is low. d_out/wrap_out/ch_out hold their last values; sync_out = 0.
- Reset asserted mid-stream: in-flight samples are discarded, and every channel re-primes on its next sample.

Test Plan:
- Reset/priming (NCH=4, WIN=8, WOUT=12, SAT=1):
  - Stimulus: hold rst_n low, check all outputs 0. Release, then ch0 d_in=100.
  - Required: sync_out exactly 2 clk later, d_out=100, wrap_out=0.
- Positive wrap, ch0:
  - Stimulus: 120, 126, -126, -100 on consecutive cycles.
  - Required: d_out = 120, 126, 130, 156; wrap_out = 0, 0, 1, 1.
- Interleave plus negative wrap:
  - Stimulus: ch1 -120, ch2 5, ch1 120 back-to-back.
  - Required: ch1 outputs -120 then -136 (wrap -1); ch2 output unaffected at 5; ch_out tracks the input channel order.
- Preload collision:
  - Stimulus: ch3 primed at 120. Next sample ch3 -126 arrives in stage B with wrap_ld=1, wrap_ld_ch=3, wrap_ld_val=5.
  - Required: wrap_out=6, d_out = 6*256 - 126 = 1410.
- Saturation:
  - Stimulus: preload ch0 to 7, then force a +1 wrap.
  - Required with SAT=1: wrap_out=7, sat_out=1, sat_flags[0]=1 until clr_sat.
  - Required with SAT=0: wrap_out=-8, sat_out=0.
- Invalid channel and reset mid-stream:
  - Stimulus: NCH=3, ch_in=3 strobed.
  - Required: no sync_out, no state change.
  - Stimulus: rst_n pulsed with two samples in flight.
  - Required: neither sample emerges; the next ch0 sample is treated as the first (delta 0).
